// File: rtl/writeback_stage.sv
// Writeback stage: selects the writeback value for the register file and the
// forwarding bus, owns the output-port register, and reassembles the words
// popped by RET/RTI into a return PC (and flags for RTI) for a fetch redirect.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | no return sequence in progress
// GOT_FLAGS | RTI flags word captured, waiting for the PC high word
// GOT_HIGH  | PC high word captured, waiting for the PC low word
// DONE      | pc_load (and flags_load for RTI) pulsing for this cycle
module writeback_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 32,
  parameter int FLAG_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] ldm_value,
  input  logic [DATA_WIDTH-1:0] alu_value,
  input  logic [DATA_WIDTH-1:0] in_port,
  input  logic                  reg_write,
  input  logic [1:0]            wb_sel,
  input  logic [2:0]            reg_write_address,
  input  logic                  outport_enable,
  input  logic                  ret_valid,
  input  logic                  ret_first,
  input  logic                  ret_is_rti,
  output logic                  rf_write_enable,
  output logic [2:0]            rf_write_address,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_value,
  output logic                  flags_load,
  output logic [FLAG_WIDTH-1:0] flags_value,
  output logic                  ret_busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GOT_FLAGS = 2'd1,
    GOT_HIGH  = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   high_word;
  logic [FLAG_WIDTH-1:0]   flags_cap;
  logic                    is_rti;
  logic                    start_seq;

  // A first word restarts the sequence from any state, abandoning partial work.
  assign start_seq = ret_valid & ret_first;

  // Writeback value select; also drives the forwarding bus, so no register here.
  always_comb begin
    rf_write_data = alu_value;
    case (wb_sel)
      2'b00:   rf_write_data = alu_value;
      2'b01:   rf_write_data = mem_data;
      2'b10:   rf_write_data = ldm_value;
      default: rf_write_data = in_port;
    endcase
  end

  assign rf_write_enable  = reg_write & ~reset;
  assign rf_write_address = reg_write_address;
  assign ret_busy         = (state != IDLE);

  // Output port register: loads the writeback value when enabled, else holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= '0;
    end else if (outport_enable) begin
      out_port <= rf_write_data;
    end
  end

  // Return-sequence FSM; pc_load/flags_load are registered one-cycle pulses
  // that coincide with the DONE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      high_word   <= '0;
      flags_cap   <= '0;
      is_rti      <= 1'b0;
      pc_load     <= 1'b0;
      pc_value    <= '0;
      flags_load  <= 1'b0;
      flags_value <= '0;
    end else begin
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      if (start_seq) begin
        is_rti <= ret_is_rti;
        if (ret_is_rti) begin
          flags_cap <= mem_data[FLAG_WIDTH-1:0];
          state     <= GOT_FLAGS;
        end else begin
          high_word <= mem_data;
          state     <= GOT_HIGH;
        end
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          GOT_FLAGS: begin
            if (ret_valid) begin
              high_word <= mem_data;
              state     <= GOT_HIGH;
            end
          end
          GOT_HIGH: begin
            if (ret_valid) begin
              pc_load  <= 1'b1;
              pc_value <= {high_word, mem_data};
              if (is_rti) begin
                flags_load  <= 1'b1;
                flags_value <= flags_cap;
              end
              state <= DONE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a queue-based scoreboard.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_data, ldm_value, alu_value, in_port;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [2:0]  reg_write_address;
  logic        outport_enable;
  logic        ret_valid, ret_first, ret_is_rti;
  logic        rf_write_enable;
  logic [2:0]  rf_write_address;
  logic [15:0] rf_write_data;
  logic [15:0] out_port;
  logic        pc_load;
  logic [31:0] pc_value;
  logic        flags_load;
  logic [2:0]  flags_value;
  logic        ret_busy;

  writeback_stage dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .ldm_value(ldm_value),
    .alu_value(alu_value), .in_port(in_port), .reg_write(reg_write),
    .wb_sel(wb_sel), .reg_write_address(reg_write_address),
    .outport_enable(outport_enable), .ret_valid(ret_valid),
    .ret_first(ret_first), .ret_is_rti(ret_is_rti),
    .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
    .rf_write_data(rf_write_data), .out_port(out_port), .pc_load(pc_load),
    .pc_value(pc_value), .flags_load(flags_load), .flags_value(flags_value),
    .ret_busy(ret_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  addr;
  } wb_exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        fl;
    logic [2:0]  flags;
  } ret_exp_t;

  wb_exp_t  wb_q[$];
  ret_exp_t ret_q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ret(input logic [31:0] pc, input logic fl, input logic [2:0] flags);
    ret_exp_t e;
    e.pc = pc;
    e.fl = fl;
    e.flags = flags;
    ret_q.push_back(e);
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a redirect.
  always @(negedge clk) begin
    if (rf_write_enable) begin
      if (wb_q.size() == 0) begin
        chk("unexpected_rf_write", 32'(rf_write_enable), 32'd0);
      end else begin
        wb_exp_t w;
        w = wb_q.pop_front();
        chk("rf_write_data", 32'(rf_write_data), 32'(w.data));
        chk("rf_write_address", 32'(rf_write_address), 32'(w.addr));
      end
    end
    if (pc_load) begin
      if (ret_q.size() == 0) begin
        chk("unexpected_pc_load", 32'(pc_load), 32'd0);
      end else begin
        ret_exp_t r;
        r = ret_q.pop_front();
        chk("pc_value", pc_value, r.pc);
        chk("flags_load", 32'(flags_load), 32'(r.fl));
        if (r.fl) chk("flags_value", 32'(flags_value), 32'(r.flags));
      end
    end else if (flags_load) begin
      chk("flags_load_without_pc_load", 32'(flags_load), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    wb_exp_t w;
    reset = 1'b1;
    mem_data = '0; ldm_value = '0; alu_value = '0; in_port = '0;
    reg_write = 1'b1; wb_sel = 2'b00; reg_write_address = 3'd0;
    outport_enable = 1'b0;
    ret_valid = 1'b0; ret_first = 1'b0; ret_is_rti = 1'b0;
    tick();
    tick();
    // Reset state, with reg_write held high to confirm write is suppressed
    chk("reset_rf_write_enable", 32'(rf_write_enable), 32'd0);
    chk("reset_out_port", 32'(out_port), 32'd0);
    chk("reset_pc_load", 32'(pc_load), 32'd0);
    chk("reset_pc_value", pc_value, 32'd0);
    chk("reset_flags_value", 32'(flags_value), 32'd0);
    chk("reset_ret_busy", 32'(ret_busy), 32'd0);
    reg_write = 1'b0;
    reset = 1'b0;
    tick();

    // Writeback mux sweep
    reg_write = 1'b1; reg_write_address = 3'd5;
    alu_value = 16'h1111; mem_data = 16'h2222; ldm_value = 16'h3333; in_port = 16'h4444;
    for (int s = 0; s < 4; s++) begin
      wb_sel = 2'(s);
      w.addr = 3'd5;
      case (s)
        0: w.data = 16'h1111;
        1: w.data = 16'h2222;
        2: w.data = 16'h3333;
        default: w.data = 16'h4444;
      endcase
      wb_q.push_back(w);
      tick();
    end
    reg_write = 1'b0;
    mem_data = '0;

    // Output port load and hold
    wb_sel = 2'b00; alu_value = 16'hBEEF; outport_enable = 1'b1;
    tick();
    chk("out_port_load", 32'(out_port), 32'h0000BEEF);
    outport_enable = 1'b0; alu_value = 16'h0000;
    tick();
    chk("out_port_hold", 32'(out_port), 32'h0000BEEF);

    // RET with one bubble between words
    busy_cnt = 0;
    ret_valid = 1'b1; ret_first = 1'b1; ret_is_rti = 1'b0; mem_data = 16'h0001;
    tick(); busy_cnt += int'(ret_busy);
    ret_valid = 1'b0; ret_first = 1'b0; mem_data = 16'h0000;
    tick(); busy_cnt += int'(ret_busy);
    ret_valid = 1'b1; mem_data = 16'h2345;
    push_ret(32'h00012345, 1'b0, 3'b000);
    tick(); busy_cnt += int'(ret_busy);
    ret_valid = 1'b0; mem_data = 16'h0000;
    tick(); busy_cnt += int'(ret_busy);
    chk("ret_busy_cycles", 32'(busy_cnt), 32'd3);
    tick();
    chk("pc_value_hold", pc_value, 32'h00012345);
    chk("pc_load_cleared", 32'(pc_load), 32'd0);

    // RTI: flags, high, low
    ret_valid = 1'b1; ret_first = 1'b1; ret_is_rti = 1'b1; mem_data = 16'h0005;
    tick();
    ret_first = 1'b0; ret_is_rti = 1'b0; mem_data = 16'h0000;
    tick();
    mem_data = 16'h0100;
    push_ret(32'h00000100, 1'b1, 3'b101);
    tick();
    ret_valid = 1'b0; mem_data = 16'h0000;
    tick();
    tick();

    // Restart abandons partial RET
    ret_valid = 1'b1; ret_first = 1'b1; mem_data = 16'hAAAA;
    tick();
    mem_data = 16'h0000;
    tick();
    ret_first = 1'b0; mem_data = 16'h0042;
    push_ret(32'h00000042, 1'b0, 3'b000);
    tick();
    ret_valid = 1'b0; mem_data = 16'h0000;
    tick();
    tick();

    // Reset while in GOT_HIGH
    ret_valid = 1'b1; ret_first = 1'b1; mem_data = 16'h1234;
    tick();
    chk("got_high_busy", 32'(ret_busy), 32'd1);
    reset = 1'b1; ret_first = 1'b0; mem_data = 16'h5678;
    tick();
    chk("midseq_reset_busy", 32'(ret_busy), 32'd0);
    chk("midseq_reset_out_port", 32'(out_port), 32'd0);
    chk("midseq_reset_pc_load", 32'(pc_load), 32'd0);
    chk("midseq_reset_pc_value", pc_value, 32'd0);
    reset = 1'b0; ret_valid = 1'b0; mem_data = 16'h0000;
    tick();
    tick();
    chk("post_reset_busy", 32'(ret_busy), 32'd0);

    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("ret_queue_drained", 32'(ret_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
